// File: rtl/priority_decoder_stretch_pkg.sv
// Purpose: shared code constants, FSM state encoding and code-legality helper
// Latency: n/a (package only)
// Backpressure: n/a
// Used by the priority decoder and by the matching 12-input priority encoder,
// which shares CODE_NONE so both ends agree on the "no request" code.
package priority_decoder_stretch_pkg;

  localparam int         N_CHAN    = 12;
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A code is legal when it names an existing output channel.
  function automatic logic is_legal_code(input int code, input int n_out = N_CHAN);
    return (code < n_out);
  endfunction

endpackage

// File: rtl/priority_decoder_stretch_sat_counter.sv
// Purpose: saturating up-counter with synchronous clear (clear beats increment)
// Latency: count visible one cycle after inc_i / clr_i
// Backpressure: none; increments past all-ones are dropped
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : add one this cycle (ignored when saturated)
//   clr_i      : return to zero next cycle, overriding inc_i
//   cnt_o      : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/priority_decoder_stretch.sv
// Purpose: code -> one-hot decoder whose selected line is stretched to HOLD_CYCLES cycles
// Latency: one-hot appears 1 cycle after accept; err_o pulses 1 cycle after an illegal accept
// Backpressure: code_ready low while a line is held (high throughout with PRIORITY_DECODER_RETRIGGER_EN)
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   code_i/code_valid/ready  : index code handshake (0..N_OUT-1 legal, all-ones = none, rest illegal)
//   onehot_o/onehot_valid    : registered one-hot line and its non-zero flag
//   err_o                    : one-cycle pulse per accepted illegal code
//   err_cnt/err_clr          : saturating illegal-code count and its synchronous clear
// Optional macro PRIORITY_DECODER_RETRIGGER_EN: accept codes during HOLD; a legal code
// replaces the line and reloads the hold time, the none code ends the hold early.
module priority_decoder_stretch
  import priority_decoder_stretch_pkg::*;
#(
  parameter int N_OUT       = 12,
  parameter int CODE_W      = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    code_i,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic [N_OUT-1:0]     onehot_o,
  output logic                 onehot_valid,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_HOLD = 1'(HOLD);

  localparam int             CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // With a single-cycle hold the only HOLD cycle is also the last one, so the
  // next code is taken on the edge that ends the pulse and the stream stays gap-free.
  localparam logic SINGLE_CYCLE = (HOLD_CYCLES == 1);

  logic [0:0]       state_q, state_d;
  logic [N_OUT-1:0] onehot_q, onehot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  logic             accept;
  logic             acc_legal;
  logic             acc_none;
  logic             acc_illegal;
  logic [N_OUT-1:0] dec_oh;

`ifdef PRIORITY_DECODER_RETRIGGER_EN
  assign code_ready = 1'b1;
`else
  assign code_ready = (state_q == ST_IDLE) || SINGLE_CYCLE;
`endif

  assign accept      = code_valid && code_ready;
  assign acc_legal   = accept && is_legal_code(int'(code_i), N_OUT);
  assign acc_none    = accept && (code_i == CODE_W'(CODE_NONE));
  assign acc_illegal = accept && !is_legal_code(int'(code_i), N_OUT) && !acc_none;
  assign dec_oh      = N_OUT'(1) << code_i;

  // Only legal codes load the line; none and illegal codes leave a running
  // hold alone unless the none code ends it (retrigger mode).
  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_legal) begin
          onehot_d = dec_oh;
          cnt_d    = CNT_LOAD;
          state_d  = ST_HOLD;
        end
      end
      default: begin
        if (acc_legal) begin
          onehot_d = dec_oh;
          cnt_d    = CNT_LOAD;
        end else if (acc_none || (cnt_q == '0)) begin
          onehot_d = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
      err_q    <= acc_illegal;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (acc_illegal),
    .clr_i (err_clr),
    .cnt_o (err_cnt)
  );

  assign onehot_o     = onehot_q;
  assign onehot_valid = |onehot_q;  // tied to the line itself so it can never disagree
  assign err_o        = err_q;

endmodule

// File: tb/tb_priority_decoder_stretch.sv
module tb_priority_decoder_stretch;

  typedef struct {
    logic [11:0] oh;
    logic        err;
  } exp_t;

`ifdef PRIORITY_DECODER_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  // main instance, HOLD_CYCLES = 4
  logic [3:0]  code_i;
  logic        code_valid;
  logic        code_ready;
  logic [11:0] onehot_o;
  logic        onehot_valid;
  logic        err_o;
  logic [7:0]  err_cnt;
  logic        err_clr;

  // second instance, HOLD_CYCLES = 1
  logic [3:0]  c1_code;
  logic        c1_valid;
  logic        c1_ready;
  logic [11:0] c1_onehot;
  logic        c1_ohv;
  logic        c1_err;
  logic [7:0]  c1_err_cnt;
  logic        c1_err_clr;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_chk;
  int n_fail;

  priority_decoder_stretch #(
    .N_OUT(12), .CODE_W(4), .HOLD_CYCLES(4), .ERR_CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .code_i(code_i), .code_valid(code_valid),
    .code_ready(code_ready), .onehot_o(onehot_o), .onehot_valid(onehot_valid),
    .err_o(err_o), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  priority_decoder_stretch #(
    .N_OUT(12), .CODE_W(4), .HOLD_CYCLES(1), .ERR_CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .code_i(c1_code), .code_valid(c1_valid),
    .code_ready(c1_ready), .onehot_o(c1_onehot), .onehot_valid(c1_ohv),
    .err_o(c1_err), .err_cnt(c1_err_cnt), .err_clr(c1_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation every cycle the DUT shows a line or an error.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv0", {31'd0, (onehot_valid === |onehot_o) && $onehot0(onehot_o)}, 32'd1);
      if (onehot_valid || err_o) begin
        if (q0.size() == 0) begin
          chk("unexpected0", {19'd0, err_o, onehot_o}, 32'd0);
        end else begin
          e0 = q0.pop_front();
          chk("out0", {19'd0, err_o, onehot_o}, {19'd0, e0.err, e0.oh});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv1", {31'd0, (c1_ohv === |c1_onehot) && $onehot0(c1_onehot)}, 32'd1);
      if (c1_ohv || c1_err) begin
        if (q1.size() == 0) begin
          chk("unexpected1", {19'd0, c1_err, c1_onehot}, 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("out1", {19'd0, c1_err, c1_onehot}, {19'd0, e1.err, e1.oh});
        end
      end
    end
  end

  // Present a code, wait (bounded) for acceptance, queue the expected outputs,
  // and return just after the accepting edge with the inputs still driven.
  task automatic send(input logic [3:0] c, input int nhold, input logic clr);
    int n;
    logic [11:0] one;
    exp_t x;
    one = 12'h001;
    @(negedge clk);
    code_i = c; code_valid = 1'b1; err_clr = clr;
    n = 0;
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) begin
      chk("ready_timeout", {31'd0, code_ready}, 32'd1);
      code_valid = 1'b0;
    end else begin
      for (int i = 0; i < nhold; i++) begin
        x.oh = one << c; x.err = 1'b0;
        q0.push_back(x);
      end
      if (c >= 4'd12 && c <= 4'd14) begin
        x.oh = 12'h000; x.err = 1'b1;
        q0.push_back(x);
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    code_valid = 1'b0; err_clr = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq1 [3];
    exp_t x;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    code_i = 4'd0; code_valid = 1'b0; err_clr = 1'b0;
    c1_code = 4'd0; c1_valid = 1'b0; c1_err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_onehot", {20'd0, onehot_o}, 32'd0);
    chk("rst_valid",  {31'd0, onehot_valid}, 32'd0);
    chk("rst_err",    {31'd0, err_o}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_ready",  {31'd0, code_ready}, 32'd1);

    // code 5, four-cycle stretch, ready low while held
    send(4'd5, 4, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      code_valid = 1'b0;
      chk("t1_onehot", {20'd0, onehot_o}, (i <= 4) ? 32'h020 : 32'h000);
      chk("t1_ready", {31'd0, code_ready}, (RT || i == 5) ? 32'd1 : 32'd0);
    end
    drain();

    // codes 0..11 back-to-back with valid held
    for (int c = 0; c < 12; c++) begin
      send(4'(c), (RT && c != 11) ? 1 : 4, 1'b0);
    end
    idle(1);
    drain();
    chk("t2_errcnt", {24'd0, err_cnt}, 32'd0);

    // none code, single illegal, saturation, clear beats increment
    send(4'd15, 0, 1'b0);
    idle(3);
    chk("t3_none_oh", {20'd0, onehot_o}, 32'd0);
    chk("t3_none_err", {31'd0, err_o}, 32'd0);
    send(4'd13, 0, 1'b0);
    idle(1);
    chk("t3_err_pulse", {31'd0, err_o}, 32'd1);
    chk("t3_errcnt1", {24'd0, err_cnt}, 32'd1);
    @(negedge clk);
    chk("t3_err_end", {31'd0, err_o}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      send(4'(12 + (i % 3)), 0, 1'b0);
    end
    idle(1);
    chk("t3_sat", {24'd0, err_cnt}, 32'd255);
    send(4'd13, 0, 1'b1);
    idle(1);
    chk("t3_clr_cnt", {24'd0, err_cnt}, 32'd0);
    chk("t3_clr_err", {31'd0, err_o}, 32'd1);
    drain();

    // reset in the middle of a hold on code 11
    send(4'd11, 2, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_oh_async", {20'd0, onehot_o}, 32'd0);
    chk("t4_v_async", {31'd0, onehot_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t4_ready", {31'd0, code_ready}, 32'd1);
    chk("t4_oh", {20'd0, onehot_o}, 32'd0);
    idle(5);
    chk("t4_no_resume", {20'd0, onehot_o}, 32'd0);
    chk("t4_ready_idle", {31'd0, code_ready}, 32'd1);
    drain();

`ifdef PRIORITY_DECODER_RETRIGGER_EN
    // code 3 retriggered by code 7 two cycles later, then early end via none code
    send(4'd3, 2, 1'b0);
    idle(1);
    send(4'd7, 4, 1'b0);
    idle(1);
    drain();
    send(4'd4, 1, 1'b0);
    send(4'd15, 0, 1'b0);
    idle(1);
    chk("t5_none_clear", {20'd0, onehot_o}, 32'd0);
    drain();
`endif

    // single-cycle hold build: 2,2,9 gap-free
    seq1[0] = 12'h004; seq1[1] = 12'h004; seq1[2] = 12'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_ready", {31'd0, c1_ready}, 32'd1);
      c1_code = (i == 2) ? 4'd9 : 4'd2;
      c1_valid = 1'b1;
      x.oh = seq1[i]; x.err = 1'b0;
      q1.push_back(x);
      @(posedge clk);
      #1 chk("t6_valid", {31'd0, c1_ohv}, 32'd1);
    end
    @(negedge clk);
    c1_valid = 1'b0;
    @(posedge clk);
    #1 chk("t6_end", {31'd0, c1_ohv}, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
